// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one result bit per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   operation request handshake (in_ready high only in IDLE)
//   op                  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   a, b                rs1 / rs2 operands, sampled only on the accept edge
//   out_valid/out_ready result handshake
//   result              XLEN-bit result, held while out_valid & !out_ready
//   busy                state != IDLE
//
// Optional feature macro: MULDIV_EARLY_OUT_EN
//   Divide by zero and multiply by zero finish straight from IDLE into DONE.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   prod_q, prod_d;       // mul: {acc, multiplier}; div: {rem, quotient}
    logic [XLEN-1:0]     result_q, result_d;
    logic                out_valid_q, out_valid_d;

    logic                a_sgn, b_sgn;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic [XLEN:0]       add_sum, trial_shift, trial_diff;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        a_sgn = ((op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6)) && a[XLEN-1];
        b_sgn = ((op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && b[XLEN-1];
        a_mag = a_sgn ? -a : a;
        b_mag = b_sgn ? -b : b;

        // Multiply step: conditional add into the upper half, then shift right.
        add_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        // Divide step: {rem, next dividend bit} minus divisor; sign bit says restore.
        trial_shift = prod_q[2*XLEN-1:XLEN-1];
        trial_diff  = trial_shift - {1'b0, mcand_q};

        prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
        quo_fix  = (sa_q ^ sb_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_fix  = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    sa_d    = a_sgn;
                    sb_d    = b_sgn;
                    mcand_d = b_mag;
                    // Same initial layout for both: zero upper half, |a| in the lower half.
                    prod_d  = {{XLEN{1'b0}}, a_mag};
                    cnt_d   = CNT_W'(XLEN);
                    state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (op[2] && (b == '0)) begin
                        result_d    = op[1] ? a : '1;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (!op[2] && ((a == '0) || (b == '0))) begin
                        result_d    = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (!op_q[2]) begin
                    prod_d = {add_sum, prod_q[XLEN-1:1]};
                end else if (!trial_diff[XLEN]) begin
                    prod_d = {trial_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
                end else begin
                    prod_d = {trial_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!op_q[2]) begin
                    result_d = (op_q == 3'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end else if (op_q[1]) begin
                    // Remainder by zero yields |a| re-signed by sa, i.e. a itself.
                    result_d = rem_fix;
                end else begin
                    result_d = (mcand_q == '0) ? '1 : quo_fix;
                end
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    result_d    = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            mcand_q     <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (XLEN=32). Expected results
// come from a plain-arithmetic RV32M model; a monitor checks value and latency.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            busy;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic seen = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          sx, sy;
        sx = int'(x);
        sy = int'(y);
        model = '0;
        case (o)
            3'd0: begin up = {32'b0, x} * {32'b0, y}; model = up[31:0]; end
            3'd1: begin sp = longint'(sx) * longint'(sy); model = sp[63:32]; end
            3'd2: begin sp = longint'(sx) * longint'({32'b0, y}); model = sp[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; model = up[63:32]; end
            3'd4: begin
                if (y == 0) model = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = x;
                else model = sx / sy;
            end
            3'd5: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) model = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = '0;
                else model = sx % sy;
            end
            default: model = (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        model_lat = XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
        // Early-out result is registered on the accept edge itself.
        if ((o[2] && y == 0) || (!o[2] && (x == 0 || y == 0))) model_lat = 0;
`endif
    endfunction

    // Monitor: pops and compares on the first cycle each result is presented.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("result_op%0d", e.op), 64'(result), 64'(e.res));
                check($sformatf("latency_op%0d", e.op), 64'(cyc - e.acc), 64'(e.lat));
            end
        end else if (!out_valid) begin
            seen = 1'b0;
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.res = model(o, x, y);
        e.acc = cyc;
        e.lat = model_lat(o, x, y);
        e.op  = o;
        exp_q.push_back(e);
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 3'($urandom);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: pick = 32'h0000_0000;
            1: pick = 32'h0000_0001;
            2: pick = 32'hFFFF_FFFF;
            3: pick = 32'h8000_0000;
            4: pick = 32'h7FFF_FFFF;
            5: pick = 32'($urandom_range(0, 20));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        int unsigned n;

        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        issue(3'd0, 32'd5, 32'd2);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd4, -32'sd7, 32'd2);
        issue(3'd6, -32'sd7, 32'd2);
        issue(3'd5, 32'd7, 32'd2);
        issue(3'd7, 32'd7, 32'd2);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd4, -32'sd5, 32'd0);
        issue(3'd5, 32'd5, 32'd0);
        issue(3'd6, -32'sd5, 32'd0);
        issue(3'd7, 32'd5, 32'd0);
        issue(3'd0, 32'd0, 32'd9);
        drain();

        // Backpressure: result must hold, new request ignored
        out_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", 64'(out_valid), 64'd1);
        held = model(3'd0, 32'd6, 32'd7);
        for (int unsigned i = 0; i < 10; i++) begin
            in_valid = (i == 3 || i == 4);
            op = 3'd3; a = 32'd100; b = 32'd200;
            @(negedge clk);
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_result_hold", 64'(result), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_idle", 64'(in_ready), 64'd1);
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_result", 64'(result), 64'd0);

        // Asynchronous reset in the middle of a divide
        issue(3'd4, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(3'd0, 32'd3, 32'd4);
        drain();

        // Randomized operations
        for (int unsigned i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
